// File: rtl/gost89_pkg.sv
// Shared definitions for the GOST 28147-89 stream controllers (CFB, ECB, MAC).
// Holds controller state encodings and the core reset/load_data protocol.
package gost89_pkg;

  localparam int BLK_W = 64;

  typedef enum logic [2:0] {
    CFB_IDLE  = 3'd0,
    CFB_ARMED = 3'd1,
    CFB_ISSUE = 3'd2,
    CFB_WAIT  = 3'd3,
    CFB_OUT   = 3'd4
  } cfb_state_e;

  typedef struct packed {
    logic rst;
    logic load;
  } core_ctrl_t;

  // Core protocol: reset held tracks gamma from core_in; a load pulse starts a block.
  localparam core_ctrl_t CORE_CTRL_IDLE  = '{rst: 1'b1, load: 1'b0};
  localparam core_ctrl_t CORE_CTRL_ISSUE = '{rst: 1'b0, load: 1'b1};
  localparam core_ctrl_t CORE_CTRL_HOLD  = '{rst: 1'b0, load: 1'b0};

  function automatic core_ctrl_t cfb_core_ctrl(input cfb_state_e st);
    core_ctrl_t c;
    case (st)
      CFB_IDLE:  c = CORE_CTRL_IDLE;
      CFB_ISSUE: c = CORE_CTRL_ISSUE;
      CFB_ARMED: c = CORE_CTRL_HOLD;
      CFB_WAIT:  c = CORE_CTRL_HOLD;
      CFB_OUT:   c = CORE_CTRL_HOLD;
      default:   c = CORE_CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gost89_cfb_stream_ctrl.sv
// Sequences IV and 64-bit blocks through an external GOST CFB core, one block in flight.
// CFB feedback lives in the core; this block only issues, waits and hands results on.
module gost89_cfb_stream_ctrl
  import gost89_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             iv_valid,
  output logic             iv_ready,
  input  logic [BLK_W-1:0] iv_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             core_reset,
  output logic             core_load,
  output logic [BLK_W-1:0] core_in,
  input  logic             core_busy,
  input  logic [BLK_W-1:0] core_out,
  output logic             busy,
  output logic [CNT_W-1:0] block_cnt
);

  cfb_state_e       state_q, state_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [BLK_W-1:0] out_q, out_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  core_ctrl_t       core_ctrl_s;

  // Next-state and datapath update; abort wins over every handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    out_d   = out_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = CFB_IDLE;
    end else begin
      case (state_q)
        CFB_IDLE: begin
          if (iv_valid) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = CFB_ARMED;
          end else begin
            state_d = CFB_IDLE;
          end
        end
        CFB_ARMED: begin
          if (in_valid) begin
            data_d  = in_data;
            last_d  = in_last;
            state_d = CFB_ISSUE;
          end else begin
            state_d = CFB_ARMED;
          end
        end
        CFB_ISSUE: begin
          state_d = CFB_WAIT;
        end
        CFB_WAIT: begin
          if (!core_busy) begin
            out_d   = core_out;
            state_d = CFB_OUT;
          end else begin
            state_d = CFB_WAIT;
          end
        end
        CFB_OUT: begin
          if (out_ready) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = last_q ? CFB_IDLE : CFB_ARMED;
          end else begin
            state_d = CFB_OUT;
          end
        end
        default: begin
          state_d = CFB_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CFB_IDLE;
      data_q  <= {BLK_W{1'b0}};
      out_q   <= {BLK_W{1'b0}};
      last_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      out_q   <= out_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_ctrl_s = cfb_core_ctrl(state_q);

  // Handshake and core controls decode the state register only.
  assign iv_ready   = (state_q == CFB_IDLE);
  assign in_ready   = (state_q == CFB_ARMED);
  assign out_valid  = (state_q == CFB_OUT);
  assign busy       = (state_q != CFB_IDLE);
  assign core_reset = core_ctrl_s.rst;
  assign core_load  = core_ctrl_s.load;
  assign core_in    = (state_q == CFB_IDLE) ? iv_data : data_q;
  assign out_data   = out_q;
  assign out_last   = last_q;
  assign block_cnt  = cnt_q;

endmodule

// File: tb/tb_gost89_cfb_stream_ctrl.sv
// Directed bench for gost89_cfb_stream_ctrl with a simple CFB-style core model (L cycles busy).
module tb_gost89_cfb_stream_ctrl;

  localparam int L = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        abort = 1'b0;
  logic        iv_valid = 1'b0;
  logic        iv_ready;
  logic [63:0] iv_data = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        core_reset;
  logic        core_load;
  logic [63:0] core_in;
  logic        core_busy;
  logic [63:0] core_out;
  logic        busy;
  logic [31:0] block_cnt;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;
  int ov_cnt = 0;

  gost89_cfb_stream_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .iv_valid(iv_valid), .iv_ready(iv_ready), .iv_data(iv_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_reset(core_reset), .core_load(core_load), .core_in(core_in),
    .core_busy(core_busy), .core_out(core_out),
    .busy(busy), .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in keystream function; the controller never sees it, only routes its result.
  function automatic logic [63:0] f(input logic [63:0] g);
    return {g[55:0], g[63:56]} ^ 64'h5A5A_C3C3_0F0F_9696;
  endfunction

  logic [63:0] gamma_m = 64'd0;
  logic [63:0] pend_m = 64'd0;
  logic [63:0] out_m = 64'd0;
  logic        busy_m = 1'b0;
  int          cnt_m = 0;

  assign core_busy = busy_m;
  assign core_out  = out_m;

  // CFB core model: reset tracks gamma, load starts an L-cycle busy window.
  always @(posedge clk) begin
    if (core_reset) begin
      gamma_m <= core_in;
      busy_m  <= 1'b0;
      cnt_m   <= 0;
    end else if (core_load) begin
      pend_m <= core_in;
      busy_m <= 1'b1;
      cnt_m  <= L;
    end else if (busy_m) begin
      if (cnt_m == 1) begin
        busy_m  <= 1'b0;
        out_m   <= f(gamma_m) ^ pend_m;
        gamma_m <= f(gamma_m) ^ pend_m;
      end
      cnt_m <= cnt_m - 1;
    end
  end

  always @(posedge clk) begin
    if (core_load) load_cnt <= load_cnt + 1;
    if (out_valid) ov_cnt <= ov_cnt + 1;
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_iv(input logic [63:0] v);
    int n = 0;
    iv_valid = 1'b1;
    iv_data  = v;
    while (!iv_ready && n < 200) begin step(); n++; end
    chk1("iv_ready_wait", iv_ready, 1'b1);
    step();
    iv_valid = 1'b0;
  endtask

  task automatic send_blk(input logic [63:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 200) begin step(); n++; end
    chk1("in_ready_wait", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [63:0] exp_d, input logic exp_l,
                          input int hold);
    int n = 0;
    int loads;
    while (!out_valid && n < 200) begin step(); n++; end
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk64({tag, "_data"}, out_data, exp_d);
    chk1({tag, "_last"}, out_last, exp_l);
    loads = load_cnt;
    for (int i = 0; i < hold; i++) begin
      step();
      chk64({tag, "_hold_data"}, out_data, exp_d);
      chk1({tag, "_hold_in_ready"}, in_ready, 1'b0);
      chk1({tag, "_hold_valid"}, out_valid, 1'b1);
    end
    chkint({tag, "_hold_loads"}, load_cnt, loads);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int loads0;
    int ov0;
    logic [63:0] c1, c2, c3, d1, d4;

    // Reset values
    repeat (3) step();
    chk1("rst_iv_ready", iv_ready, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_core_reset", core_reset, 1'b1);
    chk1("rst_core_load", core_load, 1'b0);
    chk64("rst_out_data", out_data, 64'd0);
    chk1("rst_out_last", out_last, 1'b0);
    chkint("rst_block_cnt", int'(block_cnt), 0);
    reset = 1'b0;
    step();

    // Single-block chain: out_valid arrives 3+L cycles after the in handshake cycle
    loads0 = load_cnt;
    send_iv(64'h0123_4567_89AB_CDEF);
    chk1("armed_in_ready", in_ready, 1'b1);
    chk1("armed_core_reset", core_reset, 1'b0);
    send_blk(64'h1, 1'b1);
    chk1("issue_core_load", core_load, 1'b1);
    chk64("issue_core_in", core_in, 64'h1);
    n = 1;
    while (!out_valid && n < 200) begin step(); n++; end
    chkint("single_latency", n, L + 3);
    wait_out("single", f(64'h0123_4567_89AB_CDEF) ^ 64'h1, 1'b1, 0);
    chk1("single_idle", busy, 1'b0);
    chkint("single_cnt", int'(block_cnt), 1);
    chkint("single_loads", load_cnt - loads0, 1);

    // Three-block chain with backpressure on block 2 and an IV queued behind the last block
    c1 = f(64'hFEDC_BA98_7654_3210) ^ 64'd1;
    c2 = f(c1) ^ 64'd2;
    c3 = f(c2) ^ 64'd3;
    send_iv(64'hFEDC_BA98_7654_3210);
    send_blk(64'd1, 1'b0);
    wait_out("blk1", c1, 1'b0, 0);
    chkint("blk1_cnt", int'(block_cnt), 1);
    send_blk(64'd2, 1'b0);
    wait_out("blk2", c2, 1'b0, 10);
    chkint("blk2_cnt", int'(block_cnt), 2);
    send_blk(64'd3, 1'b1);
    iv_valid = 1'b1;
    iv_data  = 64'h1111_2222_3333_4444;
    wait_out("blk3", c3, 1'b1, 0);
    chkint("chain3_cnt", int'(block_cnt), 3);
    chk1("chain3_idle_iv_ready", iv_ready, 1'b1);
    step();
    iv_valid = 1'b0;
    chk1("queued_iv_taken", in_ready, 1'b1);
    chkint("queued_iv_cnt", int'(block_cnt), 0);

    // Abort during WAIT
    d1 = f(64'h1111_2222_3333_4444) ^ 64'hAA;
    send_blk(64'hAA, 1'b0);
    wait_out("c3blk1", d1, 1'b0, 0);
    send_blk(64'hBB, 1'b0);
    repeat (5) step();
    chk1("wait_no_valid", out_valid, 1'b0);
    ov0 = ov_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk1("abort_core_reset", core_reset, 1'b1);
    chk1("abort_iv_ready", iv_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chkint("abort_cnt_held", int'(block_cnt), 1);
    send_iv(64'h0F0F_0F0F_F0F0_F0F0);
    chk1("abort_new_iv", in_ready, 1'b1);
    chkint("abort_new_iv_cnt", int'(block_cnt), 0);
    repeat (40) step();
    chkint("abort_no_out", ov_cnt, ov0);

    // Abort and in_valid together in ARMED
    loads0 = load_cnt;
    in_valid = 1'b1;
    in_data  = 64'hCC;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk1("abort_armed_iv_ready", iv_ready, 1'b1);
    chk1("abort_armed_in_ready", in_ready, 1'b0);
    repeat (3) step();
    chkint("abort_armed_loads", load_cnt, loads0);

    // Fresh chain after aborts, then reset while in OUT
    d4 = f(64'h7777_8888_9999_AAAA) ^ 64'h55;
    send_iv(64'h7777_8888_9999_AAAA);
    send_blk(64'h55, 1'b0);
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    chk1("pre_rst_valid", out_valid, 1'b1);
    chk64("pre_rst_data", out_data, d4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_iv_ready", iv_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_core_reset", core_reset, 1'b1);
    chk64("midrst_out_data", out_data, 64'd0);
    chk1("midrst_out_last", out_last, 1'b0);
    chkint("midrst_cnt", int'(block_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
